i2c_ram_bank_controller: RTL and testbench

I2C_RAM_BANK_CONTROLLER -- requirements
Module: i2c_ram_bank_controller

---
 rtl/i2c_ram_pkg.sv | 8 +
 rtl/i2c_ram_bank_controller_if.sv | 42 ++++
 rtl/i2c_ram_bank.sv | 32 +++
 rtl/i2c_ram_bank_controller.sv | 112 +++++++++++
 tb/tb_i2c_ram_bank_controller.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_ram_pkg.sv
// i2c_ram_pkg: shared parameter defaults and clear FSM encoding for the RAM bank controller
package i2c_ram_pkg;
    localparam int         DATA_W_DEF     = 8;
    localparam int         ADDR_W_DEF     = 5;
    localparam int         NUM_BANKS_DEF  = 2;
    localparam logic [7:0] CLEAR_WORD_DEF = 8'h20;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
endpackage

// File: rtl/i2c_ram_bank_controller_if.sv
// i2c_ram_bank_controller_if: UI, I2C bus and clear-control signals of the bank controller
interface i2c_ram_bank_controller_if
    import i2c_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SEL_W  = 1
);
    logic [SEL_W-1:0]  ui_rsel;
    logic [ADDR_W-1:0] ui_radd;
    logic [DATA_W-1:0] ui_rdout;
    logic              ui_we;
    logic [SEL_W-1:0]  ui_wsel;
    logic [ADDR_W-1:0] ui_wadd;
    logic [DATA_W-1:0] ui_din;
    logic              ui_wready;
    logic              bus_we;
    logic [SEL_W-1:0]  bus_wsel;
    logic [ADDR_W-1:0] bus_wadd;
    logic [DATA_W-1:0] bus_din;
    logic              bus_re;
    logic [SEL_W-1:0]  bus_rsel;
    logic [ADDR_W-1:0] bus_radd;
    logic [DATA_W-1:0] bus_rdout;
    logic              bus_rvalid;
    logic              clear_req;
    logic [SEL_W-1:0]  clear_sel;
    logic              clear_busy;
    logic              clear_done;
    modport slave (
        input  ui_rsel, ui_radd, ui_we, ui_wsel, ui_wadd, ui_din,
        input  bus_we, bus_wsel, bus_wadd, bus_din, bus_re, bus_rsel, bus_radd,
        input  clear_req, clear_sel,
        output ui_rdout, ui_wready, bus_rdout, bus_rvalid, clear_busy, clear_done
    );
    modport master (
        output ui_rsel, ui_radd, ui_we, ui_wsel, ui_wadd, ui_din,
        output bus_we, bus_wsel, bus_wadd, bus_din, bus_re, bus_rsel, bus_radd,
        output clear_req, clear_sel,
        input  ui_rdout, ui_wready, bus_rdout, bus_rvalid, clear_busy, clear_done
    );
endinterface

// File: rtl/i2c_ram_bank.sv
// i2c_ram_bank: one RAM bank, single write port and two read-first synchronous read ports
module i2c_ram_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wadd_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [ADDR_W-1:0] a_radd_i,
    output logic [DATA_W-1:0] a_rdout_o,
    input  logic              b_re_i,
    input  logic [ADDR_W-1:0] b_radd_i,
    output logic [DATA_W-1:0] b_rdout_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    // storage array is deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wadd_i] <= din_i;
    end
    // read registers sample the array before this edge's write lands; port b holds without a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdout_o <= '0;
            b_rdout_o <= '0;
        end else begin
            a_rdout_o <= mem_q[a_radd_i];
            if (b_re_i) b_rdout_o <= mem_q[b_radd_i];
        end
    end
endmodule

// File: rtl/i2c_ram_bank_controller.sv
// i2c_ram_bank_controller: per-bank write arbitration (bus > UI > clear), read muxing and bank clear FSM
module i2c_ram_bank_controller
    import i2c_ram_pkg::*;
#(
    parameter int              DATA_W     = DATA_W_DEF,
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              NUM_BANKS  = NUM_BANKS_DEF,
    parameter logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(CLEAR_WORD_DEF)
) (
    input logic                         clk,
    input logic                         rst_n,
    i2c_ram_bank_controller_if.slave    bif
);
    localparam int SEL_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;

    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return 32'(s) < NUM_BANKS;
    endfunction

    logic [DATA_W-1:0] ui_rd [NUM_BANKS];
    logic [DATA_W-1:0] bus_rd [NUM_BANKS];
    logic [SEL_W-1:0]  ui_sel_q, bus_sel_q, clr_sel_q, clr_sel_d;
    logic              ui_ok_q, bus_ok_q, rvalid_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    clr_state_e        state_q, state_d;
    logic              ui_wready, stall;

    assign ui_wready = bif.ui_we && sel_ok(bif.ui_wsel) && !(bif.bus_we && bif.bus_wsel == bif.ui_wsel);
    assign stall     = (bif.bus_we && bif.bus_wsel == clr_sel_q) || (ui_wready && bif.ui_wsel == clr_sel_q);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              bus_hit, ui_hit, clr_hit;
        logic [ADDR_W-1:0] wadd;
        logic [DATA_W-1:0] din;
        assign bus_hit = bif.bus_we && bif.bus_wsel == SEL_W'(b);
        assign ui_hit  = ui_wready && bif.ui_wsel == SEL_W'(b);
        assign clr_hit = state_q == CLEAR && clr_sel_q == SEL_W'(b);
        assign wadd    = bus_hit ? bif.bus_wadd : ui_hit ? bif.ui_wadd : ptr_q;
        assign din     = bus_hit ? bif.bus_din : ui_hit ? bif.ui_din : CLEAR_WORD;
        i2c_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .we_i      (bus_hit || ui_hit || clr_hit),
            .wadd_i    (wadd),
            .din_i     (din),
            .a_radd_i  (bif.ui_radd),
            .a_rdout_o (ui_rd[b]),
            .b_re_i    (bif.bus_re),
            .b_radd_i  (bif.bus_radd),
            .b_rdout_o (bus_rd[b])
        );
    end

    // remember which bank each read targeted so the mux and invalid-select zeroing align with the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_sel_q  <= '0;
            ui_ok_q   <= 1'b0;
            bus_sel_q <= '0;
            bus_ok_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            ui_sel_q <= bif.ui_rsel;
            ui_ok_q  <= sel_ok(bif.ui_rsel);
            rvalid_q <= bif.bus_re;
            if (bif.bus_re) begin
                bus_sel_q <= bif.bus_rsel;
                bus_ok_q  <= sel_ok(bif.bus_rsel);
            end
        end
    end

    assign bif.ui_rdout   = ui_ok_q ? ui_rd[ui_sel_q] : '0;
    assign bif.bus_rdout  = bus_ok_q ? bus_rd[bus_sel_q] : '0;
    assign bif.bus_rvalid = rvalid_q;
    assign bif.ui_wready  = ui_wready;
    assign bif.clear_busy = state_q != IDLE;
    assign bif.clear_done = state_q == DONE;

    // clear FSM state, pointer and latched bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            clr_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            clr_sel_q <= clr_sel_d;
        end
    end

    // clear sequencing: one word per cycle, pointer held whenever a bus or UI write owns the bank
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_sel_d = clr_sel_q;
        case (state_q)
            IDLE: if (bif.clear_req && sel_ok(bif.clear_sel)) begin
                state_d   = CLEAR;
                ptr_d     = '0;
                clr_sel_d = bif.clear_sel;
            end
            CLEAR: if (!stall) begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_ram_bank_controller.sv
// tb_i2c_ram_bank_controller: scoreboard bench with a behavioural RAM/clear model and randomized traffic
module tb_i2c_ram_bank_controller;
    localparam int DW = 8, AW = 5, NB = 3, SW = 2, DEPTH = 32, CW = 'h20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_ram_bank_controller_if #(.DATA_W(DW), .ADDR_W(AW), .SEL_W(SW)) bif ();
    i2c_ram_bank_controller #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif.slave)
    );

    int mem [NB][DEPTH];
    bit clr_act, clr_done_ph;
    int clr_bank, clr_ptr;
    int sbq [$];
    int hold_exp;
    int mon_e;
    int n_cmp = 0, n_bad = 0;

    function automatic bit ok(input int s);
        return s < NB;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bif.ui_rsel = '0; bif.ui_radd = '0; bif.ui_we = 1'b0; bif.ui_wsel = '0;
        bif.ui_wadd = '0; bif.ui_din = '0;
        bif.bus_we = 1'b0; bif.bus_wsel = '0; bif.bus_wadd = '0; bif.bus_din = '0;
        bif.bus_re = 1'b0; bif.bus_rsel = '0; bif.bus_radd = '0;
        bif.clear_req = 1'b0; bif.clear_sel = '0;
    endtask

    // one clock: check combinational outputs, advance the model, then check the registered UI read
    task automatic tick();
        int exp_ui;
        bit wr_ok, bus_ok, stall;
        #1;
        wr_ok = bif.ui_we && ok(bif.ui_wsel) && !(bif.bus_we && bif.bus_wsel == bif.ui_wsel);
        chk("ui_wready", bif.ui_wready, wr_ok);
        chk("clear_busy", bif.clear_busy, clr_act || clr_done_ph);
        chk("clear_done", bif.clear_done, clr_done_ph);
        exp_ui = ok(bif.ui_rsel) ? mem[bif.ui_rsel][bif.ui_radd] : 0;
        if (bif.bus_re) sbq.push_back(ok(bif.bus_rsel) ? mem[bif.bus_rsel][bif.bus_radd] : 0);
        bus_ok = bif.bus_we && ok(bif.bus_wsel);
        stall = (bus_ok && bif.bus_wsel == clr_bank) || (wr_ok && bif.ui_wsel == clr_bank);
        if (bus_ok) mem[bif.bus_wsel][bif.bus_wadd] = bif.bus_din;
        if (wr_ok) mem[bif.ui_wsel][bif.ui_wadd] = bif.ui_din;
        if (clr_done_ph) clr_done_ph = 0;
        else if (clr_act) begin
            if (!stall) begin
                mem[clr_bank][clr_ptr] = CW;
                clr_ptr++;
                if (clr_ptr == DEPTH) begin
                    clr_act = 0;
                    clr_done_ph = 1;
                end
            end
        end else if (bif.clear_req && ok(bif.clear_sel)) begin
            clr_act = 1;
            clr_bank = bif.clear_sel;
            clr_ptr = 0;
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_ui >= 0) chk("ui_rdout", bif.ui_rdout, exp_ui);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ui_rdout", bif.ui_rdout, 0);
        chk("rst_bus_rdout", bif.bus_rdout, 0);
        chk("rst_bus_rvalid", bif.bus_rvalid, 0);
        chk("rst_clear_busy", bif.clear_busy, 0);
        chk("rst_clear_done", bif.clear_done, 0);
        clr_act = 0;
        clr_done_ph = 0;
        sbq.delete();
        hold_exp = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input int s, input int a, input int d);
        idle();
        bif.bus_we = 1'b1; bif.bus_wsel = SW'(s); bif.bus_wadd = AW'(a); bif.bus_din = DW'(d);
        tick();
    endtask

    task automatic readback();
        for (int s = 0; s <= NB; s++)
            for (int a = 0; a < DEPTH; a++) begin
                idle();
                bif.bus_re = 1'b1; bif.bus_rsel = SW'(s); bif.bus_radd = AW'(a);
                bif.ui_rsel = SW'(s); bif.ui_radd = AW'(a);
                tick();
            end
        idle();
        tick();
    endtask

    task automatic start_clear(input int s);
        idle();
        bif.clear_req = 1'b1; bif.clear_sel = SW'(s);
        tick();
        idle();
    endtask

    // scoreboard monitor: every bus_rvalid pops one expected word; otherwise bus_rdout must hold
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.bus_rvalid) begin
                if (sbq.size() == 0) chk("bus_rvalid_spurious", 1, 0);
                else begin
                    mon_e = sbq.pop_front();
                    hold_exp = mon_e;
                    if (mon_e >= 0) chk("bus_rdout", bif.bus_rdout, mon_e);
                end
            end else begin
                if (sbq.size() != 0) begin
                    chk("bus_rvalid_missing", 0, 1);
                    void'(sbq.pop_front());
                end
                if (hold_exp >= 0) chk("bus_rdout_hold", bif.bus_rdout, hold_exp);
            end
        end
    end

    initial begin
        int cnt, dn;
        idle();
        foreach (mem[s, a]) mem[s][a] = -1;
        hold_exp = 0;
        @(negedge clk);
        do_reset();
        for (int s = 0; s < NB; s++)
            for (int a = 0; a < DEPTH; a++) bus_write(s, a, $urandom_range(0, 255));
        // bus write then read back, plus read-first on a same-cycle write/read
        bus_write(1, 3, 'h41);
        idle(); bif.bus_re = 1'b1; bif.bus_rsel = 2'd1; bif.bus_radd = 5'd3; tick();
        idle(); bif.bus_re = 1'b1; bif.bus_rsel = 2'd1; bif.bus_radd = 5'd3;
        bif.bus_we = 1'b1; bif.bus_wsel = 2'd1; bif.bus_wadd = 5'd3; bif.bus_din = 8'h42; tick();
        // bus and UI collide on bank0; UI retries next cycle
        idle(); bif.bus_we = 1'b1; bif.bus_wsel = 2'd0; bif.bus_wadd = 5'd4; bif.bus_din = 8'h11;
        bif.ui_we = 1'b1; bif.ui_wsel = 2'd0; bif.ui_wadd = 5'd5; bif.ui_din = 8'h22; tick();
        bif.bus_we = 1'b0; tick();
        idle(); bif.ui_we = 1'b1; bif.ui_wsel = 2'd3; bif.ui_din = 8'h99; tick();
        bus_write(3, 7, 'h77);
        // full clear of bank0 after filling with FF; stray requests while busy are ignored
        for (int a = 0; a < DEPTH; a++) bus_write(0, a, 'hFF);
        start_clear(0);
        cnt = 0; dn = 0;
        for (int i = 0; i < 100 && bif.clear_busy; i++) begin
            cnt++;
            if (bif.clear_done) dn++;
            idle();
            if (i == 3) begin bif.clear_req = 1'b1; bif.clear_sel = 2'd1; end
            tick();
        end
        chk("clear_busy_cycles", cnt, 33);
        chk("clear_done_pulses", dn, 1);
        readback();
        // invalid clear_sel is ignored
        start_clear(3);
        tick();
        // clear with two bus writes landing on the bank being cleared
        start_clear(0);
        cnt = 0;
        for (int i = 0; i < 100 && bif.clear_busy; i++) begin
            cnt++;
            idle();
            if (i == 4) begin bif.bus_we = 1'b1; bif.bus_wsel = 2'd0; bif.bus_wadd = 5'd31; bif.bus_din = 8'hAA; end
            if (i == 5) begin bif.bus_we = 1'b1; bif.bus_wsel = 2'd0; bif.bus_wadd = 5'd0; bif.bus_din = 8'h55; end
            tick();
        end
        chk("clear_stall_cycles", cnt, 35);
        readback();
        // reset in the middle of a clear
        for (int a = 0; a < DEPTH; a++) bus_write(0, a, $urandom_range(0, 255));
        start_clear(0);
        for (int i = 0; i < 100 && clr_ptr < 10; i++) tick();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        readback();
        // randomized traffic including invalid selects and clear requests
        for (int i = 0; i < 800; i++) begin
            bif.ui_rsel = SW'($urandom_range(0, 3)); bif.ui_radd = AW'($urandom);
            bif.ui_we = ($urandom_range(0, 1) == 1); bif.ui_wsel = SW'($urandom_range(0, 3));
            bif.ui_wadd = AW'($urandom); bif.ui_din = DW'($urandom);
            bif.bus_we = ($urandom_range(0, 2) == 0); bif.bus_wsel = SW'($urandom_range(0, 3));
            bif.bus_wadd = AW'($urandom); bif.bus_din = DW'($urandom);
            bif.bus_re = ($urandom_range(0, 1) == 1); bif.bus_rsel = SW'($urandom_range(0, 3));
            bif.bus_radd = AW'($urandom);
            bif.clear_req = ($urandom_range(0, 15) == 0); bif.clear_sel = SW'($urandom_range(0, 3));
            tick();
        end
        idle();
        for (int i = 0; i < 100 && bif.clear_busy; i++) tick();
        chk("final_clear_idle", bif.clear_busy, 0);
        readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
